// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
// Turns button inputs into a clamped (x,y) position and an 8-way heading.
// Updates happen once per movement tick. A tick is one UPDATE cycle that
// follows TICK_CYCLES cycles of WAIT, so ticks are TICK_CYCLES+1 cycles apart.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   enable     1 runs the tick engine; 0 returns to IDLE and freezes outputs
//   turn_left  rotate heading +1 (CCW)
//   turn_right rotate heading -1 (CW)
//   fwd/back   move along / opposite to the heading
//   flip_vert  invert the y component of motion
//   x_pos      current x (X_W bits)
//   y_pos      current y (Y_W bits)
//   heading    current heading, 0..7:
//              0=+x, 1=+x-y, 2=-y, 3=-x-y, 4=-x, 5=-x+y, 6=+y, 7=+x+y
//   tick       1-cycle pulse during the UPDATE cycle
//   moving     the position changed at the last UPDATE
//   at_wall    a clamp occurred at the last UPDATE
//
// Build option: define PLAYER_SYNC_EN to pass the button inputs through
// two-flop synchronisers. Without it, the buttons are sampled directly.
module player_motion_ctrl #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int STEP        = 1,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 620,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 460,
  parameter int X_INIT      = 310,
  parameter int Y_INIT      = 230,
  parameter int ROT_HOLD    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           turn_left,
  input  logic           turn_right,
  input  logic           fwd,
  input  logic           back,
  input  logic           flip_vert,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic [2:0]     heading,
  output logic           tick,
  output logic           moving,
  output logic           at_wall
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam int ROT_W = (ROT_HOLD > 1) ? $clog2(ROT_HOLD) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(ROT_HOLD - 1);

  localparam logic signed [X_W+1:0] XSTEP  = (X_W+2)'(STEP);
  localparam logic signed [X_W+1:0] XMIN_S = (X_W+2)'(X_MIN);
  localparam logic signed [X_W+1:0] XMAX_S = (X_W+2)'(X_MAX);
  localparam logic signed [Y_W+1:0] YSTEP  = (Y_W+2)'(STEP);
  localparam logic signed [Y_W+1:0] YMIN_S = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] YMAX_S = (Y_W+2)'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROT_W-1:0] rot_cnt_q, rot_cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [2:0]       heading_q, heading_d;
  logic             moving_q, moving_d;
  logic             at_wall_q, at_wall_d;
  logic             upd;

  logic tl_s, tr_s, fwd_s, back_s, flip_s;

`ifdef PLAYER_SYNC_EN
  logic [4:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {turn_left, turn_right, fwd, back, flip_vert};
      sync2_q <= sync1_q;
    end
  end
  assign {tl_s, tr_s, fwd_s, back_s, flip_s} = sync2_q;
`else
  assign {tl_s, tr_s, fwd_s, back_s, flip_s} =
    {turn_left, turn_right, fwd, back, flip_vert};
`endif

  // Tick engine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cnt_q == TICK_LAST) begin
            state_d = S_UPDATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_UPDATE: begin
          upd     = 1'b1;
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Motion, clamping and rotation. The direction is taken from the heading
  // before this tick's rotation.
  logic                   mv, x_inc, x_dec, y_inc, y_dec, x_clamp, y_clamp;
  logic [2:0]             dir;
  logic signed [X_W+1:0]  x_ext, x_cand;
  logic signed [Y_W+1:0]  y_ext, y_cand;

  always_comb begin
    mv    = fwd_s ^ back_s;
    dir   = back_s ? (heading_q + 3'd4) : heading_q;
    x_inc = 1'b0;
    x_dec = 1'b0;
    y_inc = 1'b0;
    y_dec = 1'b0;
    if (mv) begin
      unique case (dir)
        3'd0: x_inc = 1'b1;
        3'd1: begin x_inc = 1'b1; y_dec = 1'b1; end
        3'd2: y_dec = 1'b1;
        3'd3: begin x_dec = 1'b1; y_dec = 1'b1; end
        3'd4: x_dec = 1'b1;
        3'd5: begin x_dec = 1'b1; y_inc = 1'b1; end
        3'd6: y_inc = 1'b1;
        default: begin x_inc = 1'b1; y_inc = 1'b1; end
      endcase
    end
    if (flip_s) begin
      {y_inc, y_dec} = {y_dec, y_inc};
    end

    x_ext  = $signed({2'b00, x_q});
    y_ext  = $signed({2'b00, y_q});
    x_cand = x_ext;
    y_cand = y_ext;
    if (x_inc) x_cand = x_ext + XSTEP;
    if (x_dec) x_cand = x_ext - XSTEP;
    if (y_inc) y_cand = y_ext + YSTEP;
    if (y_dec) y_cand = y_ext - YSTEP;

    x_clamp = 1'b0;
    y_clamp = 1'b0;
    if (x_cand < XMIN_S) begin
      x_cand  = XMIN_S;
      x_clamp = 1'b1;
    end else if (x_cand > XMAX_S) begin
      x_cand  = XMAX_S;
      x_clamp = 1'b1;
    end
    if (y_cand < YMIN_S) begin
      y_cand  = YMIN_S;
      y_clamp = 1'b1;
    end else if (y_cand > YMAX_S) begin
      y_cand  = YMAX_S;
      y_clamp = 1'b1;
    end

    x_d       = x_q;
    y_d       = y_q;
    heading_d = heading_q;
    rot_cnt_d = rot_cnt_q;
    moving_d  = moving_q;
    at_wall_d = at_wall_q;

    if (upd) begin
      x_d       = x_cand[X_W-1:0];
      y_d       = y_cand[Y_W-1:0];
      moving_d  = (x_cand[X_W-1:0] != x_q) || (y_cand[Y_W-1:0] != y_q);
      at_wall_d = x_clamp | y_clamp;
      if (!(tl_s ^ tr_s)) begin
        rot_cnt_d = '0;
      end else if (rot_cnt_q == '0) begin
        heading_d = tl_s ? (heading_q + 3'd1) : (heading_q - 3'd1);
        rot_cnt_d = ROT_LAST;
      end else begin
        rot_cnt_d = rot_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rot_cnt_q <= '0;
      x_q       <= X_W'(X_INIT);
      y_q       <= Y_W'(Y_INIT);
      heading_q <= 3'd0;
      moving_q  <= 1'b0;
      at_wall_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rot_cnt_q <= rot_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      heading_q <= heading_d;
      moving_q  <= moving_d;
      at_wall_q <= at_wall_d;
    end
  end

  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign heading = heading_q;
  assign tick    = upd;
  assign moving  = moving_q;
  assign at_wall = at_wall_q;

endmodule
